// File: rtl/sm_prog_loader.sv
// Program loader: receives framed instruction words over a byte stream,
// writes them into instruction memory and holds the CPU in reset until a
// frame with a good checksum has been loaded.
//
// Stream handshake: a byte moves when in_valid && in_ready are both high at
// a rising edge; in_valid and in_data stay stable until that edge, and
// in_ready is low only in the cycle that carries the mem_we strobe.
module sm_prog_loader #(
  parameter int ADDR_WIDTH = 6,
  parameter int TIMEOUT    = 120
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  cpu_rst_n,
  output logic                  done,
  output logic                  error,
  output logic [2:0]            dbgState
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [7:0] HEADER = 8'hA5;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    COUNT = 3'd1,
    DATA  = 3'd2,
    CHECK = 3'd3,
    RUN   = 3'd4,
    ERR   = 3'd5
  } stateT;

  stateT                 state;
  stateT                 nextState;
  logic                  accept;
  logic                  inFrame;
  logic                  wordDone;
  logic                  timeoutHit;
  logic                  countTooBig;
  logic [1:0]            byteIdx;
  logic [ADDR_WIDTH-1:0] wordIdx;
  logic [ADDR_WIDTH-1:0] lastIdx;
  logic [31:0]           shiftReg;
  logic [7:0]            chk;
  logic [TW-1:0]         idleCnt;

  // The write strobe cycle is the only cycle in which no byte is taken.
  assign in_ready = !mem_we;
  assign accept   = in_valid && in_ready;
  assign dbgState = state;

  assign inFrame     = (state == COUNT) || (state == DATA) || (state == CHECK);
  assign wordDone    = accept && (state == DATA) && (byteIdx == 2'd3);
  assign timeoutHit  = inFrame && !accept && (idleCnt == TW'(TIMEOUT - 1));
  assign countTooBig = 32'(in_data) > DEPTH;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nextState;
  end

  // Next-state logic; a timeout overrides any in-frame decision.
  always_comb begin
    nextState = state;
    case (state)
      IDLE, RUN, ERR: begin
        if (accept && in_data == HEADER) nextState = COUNT;
      end
      COUNT: begin
        if (accept) begin
          if (countTooBig)          nextState = ERR;
          else if (in_data == 8'd0) nextState = CHECK;
          else                      nextState = DATA;
        end
      end
      DATA: begin
        if (wordDone && wordIdx == lastIdx) nextState = CHECK;
      end
      CHECK: begin
        if (accept) nextState = (in_data == chk) ? RUN : ERR;
      end
      default: nextState = IDLE;
    endcase
    if (timeoutHit) nextState = ERR;
  end

  // Word assembly, write strobe and running checksum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      shiftReg  <= '0;
      byteIdx   <= '0;
      wordIdx   <= '0;
      lastIdx   <= '0;
      chk       <= '0;
    end else begin
      mem_we <= wordDone;
      if (nextState == COUNT && state != COUNT) begin
        chk <= '0;
      end
      if (state == COUNT && accept) begin
        lastIdx <= ADDR_WIDTH'(in_data - 8'd1);
        wordIdx <= '0;
        byteIdx <= '0;
      end
      if (state == DATA && accept) begin
        // First byte of a word ends up in bits 7:0 after four shifts.
        shiftReg <= {in_data, shiftReg[31:8]};
        byteIdx  <= byteIdx + 2'd1;
        chk      <= chk ^ in_data;
      end
      if (wordDone) begin
        mem_addr  <= wordIdx;
        mem_wdata <= {in_data, shiftReg[31:8]};
        wordIdx   <= wordIdx + 1'b1;
      end
    end
  end

  // Idle counter: runs only inside a frame, cleared by every accepted byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 idleCnt <= '0;
    else if (accept || !inFrame) idleCnt <= '0;
    else                        idleCnt <= idleCnt + 1'b1;
  end

  // Registered status outputs derived from the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_rst_n <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      cpu_rst_n <= (nextState == RUN);
      done      <= (nextState == RUN);
      if (nextState == ERR)                              error <= 1'b1;
      else if (nextState == COUNT || nextState == RUN)   error <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sm_prog_loader.sv
// Bench for sm_prog_loader: cycle-by-cycle vector table for full frames,
// then hand-written timeout and mid-frame reset sequences.
module tb_sm_prog_loader;

  localparam int AW = 6;
  localparam int W  = AW + 32;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          cpu_rst_n;
  logic          done;
  logic          error;
  logic [2:0]    dbgState;

  int total;
  int bad;
  bit scbOn;
  logic [W-1:0] exp_q[$];

  typedef struct {
    logic          valid;
    logic [7:0]    data;
    logic          rdy;
    logic          we;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic          cpu;
    logic          dn;
    logic          err;
  } vecT;

  vecT vecs[$];

  sm_prog_loader #(.ADDR_WIDTH(AW), .TIMEOUT(120)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .cpu_rst_n(cpu_rst_n), .done(done),
    .error(error), .dbgState(dbgState)
  );

  // Clock and global time limit.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got stuck want finish");
    $fatal(1, "bench time limit");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic addVec(input logic v, input logic [7:0] d, input logic r, input logic we,
                        input logic [AW-1:0] a, input logic [31:0] wd,
                        input logic c, input logic dn, input logic e);
    vecT t;
    t.valid = v; t.data = d; t.rdy = r; t.we = we; t.addr = a;
    t.wdata = wd; t.cpu = c; t.dn = dn; t.err = e;
    vecs.push_back(t);
  endtask

  // Driver: holds the byte until the loader takes it (bounded wait).
  task automatic sendByte(input logic [7:0] b);
    int guard;
    guard = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 10) check("send_stall", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Scoreboard: every write seen while enabled must match the next expected one.
  always @(negedge clk) begin
    if (scbOn && rst_n && mem_we) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", 64'({mem_addr, mem_wdata}), 64'd0);
      end else begin
        check("write", 64'({mem_addr, mem_wdata}), 64'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    logic [63:0] act;
    logic [63:0] exp;
    total = 0;
    bad   = 0;
    scbOn = 1'b0;
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;

    // Frame 1: good checksum (payload XOR is 0xB0), in_valid held high.
    addVec(1, 8'h33, 1, 0, 0, 32'h0, 0, 0, 0);
    addVec(1, 8'hA5, 1, 0, 0, 32'h0, 0, 0, 0);
    addVec(1, 8'h02, 1, 0, 0, 32'h0, 0, 0, 0);
    addVec(1, 8'h13, 1, 0, 0, 32'h0, 0, 0, 0);
    addVec(1, 8'h05, 1, 0, 0, 32'h0, 0, 0, 0);
    addVec(1, 8'h10, 1, 0, 0, 32'h0, 0, 0, 0);
    addVec(1, 8'h00, 0, 1, 0, 32'h00100513, 0, 0, 0);
    addVec(1, 8'h93, 1, 0, 0, 32'h00100513, 0, 0, 0);
    addVec(1, 8'h93, 1, 0, 0, 32'h00100513, 0, 0, 0);
    addVec(1, 8'h05, 1, 0, 0, 32'h00100513, 0, 0, 0);
    addVec(1, 8'h20, 1, 0, 0, 32'h00100513, 0, 0, 0);
    addVec(1, 8'h00, 0, 1, 1, 32'h00200593, 0, 0, 0);
    addVec(1, 8'hB0, 1, 0, 1, 32'h00200593, 0, 0, 0);
    addVec(1, 8'hB0, 1, 0, 1, 32'h00200593, 1, 1, 0);
    addVec(0, 8'h00, 1, 0, 1, 32'h00200593, 1, 1, 0);
    // Frame 2: same payload, bad checksum; writes still happen.
    addVec(1, 8'hA5, 1, 0, 1, 32'h00200593, 0, 0, 0);
    addVec(1, 8'h02, 1, 0, 1, 32'h00200593, 0, 0, 0);
    addVec(1, 8'h13, 1, 0, 1, 32'h00200593, 0, 0, 0);
    addVec(1, 8'h05, 1, 0, 1, 32'h00200593, 0, 0, 0);
    addVec(1, 8'h10, 1, 0, 1, 32'h00200593, 0, 0, 0);
    addVec(1, 8'h00, 0, 1, 0, 32'h00100513, 0, 0, 0);
    addVec(1, 8'h93, 1, 0, 0, 32'h00100513, 0, 0, 0);
    addVec(1, 8'h93, 1, 0, 0, 32'h00100513, 0, 0, 0);
    addVec(1, 8'h05, 1, 0, 0, 32'h00100513, 0, 0, 0);
    addVec(1, 8'h20, 1, 0, 0, 32'h00100513, 0, 0, 0);
    addVec(1, 8'h00, 0, 1, 1, 32'h00200593, 0, 0, 0);
    addVec(1, 8'hFF, 1, 0, 1, 32'h00200593, 0, 0, 0);
    addVec(1, 8'hFF, 1, 0, 1, 32'h00200593, 0, 0, 1);
    // Frame 3: count 0x41 exceeds depth 64, then an empty frame.
    addVec(1, 8'hA5, 1, 0, 1, 32'h00200593, 0, 0, 0);
    addVec(1, 8'h41, 1, 0, 1, 32'h00200593, 0, 0, 1);
    addVec(1, 8'hA5, 1, 0, 1, 32'h00200593, 0, 0, 0);
    addVec(1, 8'h00, 1, 0, 1, 32'h00200593, 0, 0, 0);
    addVec(1, 8'h00, 1, 0, 1, 32'h00200593, 1, 1, 0);

    // Reset values.
    repeat (3) @(posedge clk);
    #1;
    check("reset_asserted", 64'({mem_we, mem_addr, mem_wdata, cpu_rst_n, done, error, dbgState}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reset_ready", 64'(in_ready), 64'd1);

    // Table vectors.
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      in_valid = vecs[i].valid;
      in_data  = vecs[i].data;
      @(posedge clk);
      #1;
      act = 64'({in_ready, mem_we, mem_addr, mem_wdata, cpu_rst_n, done, error});
      exp = 64'({vecs[i].rdy, vecs[i].we, vecs[i].addr, vecs[i].wdata,
                 vecs[i].cpu, vecs[i].dn, vecs[i].err});
      check($sformatf("vec%0d", i), act, exp);
    end
    @(negedge clk);
    in_valid = 1'b0;
    scbOn = 1'b1;

    // Timeout: one word announced, two bytes sent, then silence.
    sendByte(8'hA5);
    sendByte(8'h01);
    sendByte(8'h13);
    sendByte(8'h05);
    repeat (119) @(posedge clk);
    #1;
    check("timeout_early", 64'(error), 64'd0);
    @(posedge clk);
    #1;
    check("timeout_error", 64'({error, done, cpu_rst_n}), 64'b100);
    sendByte(8'hA5);
    check("timeout_recover", 64'({error, dbgState}), 64'({1'b0, 3'd1}));
    sendByte(8'h00);
    sendByte(8'h00);
    check("empty_frame_run", 64'({done, cpu_rst_n, error}), 64'b110);

    // Reset in the middle of a word: nothing may be written.
    sendByte(8'hA5);
    sendByte(8'h01);
    sendByte(8'h11);
    sendByte(8'h22);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midframe_reset", 64'({mem_we, mem_addr, mem_wdata, cpu_rst_n, done, error, dbgState}), 64'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Fresh frame after reset loads normally (checksum DE^AD^BE^EF = 0x22).
    exp_q.push_back({6'd0, 32'hEFBEADDE});
    sendByte(8'hA5);
    sendByte(8'h01);
    sendByte(8'hDE);
    sendByte(8'hAD);
    sendByte(8'hBE);
    sendByte(8'hEF);
    sendByte(8'h22);
    check("reload_done", 64'({done, cpu_rst_n, error}), 64'b110);
    repeat (2) @(negedge clk);
    check("writes_drained", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
